poly5_arbiter: RTL and testbench

- Round-robin arbiter that shares one poly5 HLS component between NUM_REQ requesters.
- Each requester submits an idx with a valid/ready handshake.
- The arbiter issues it to poly5 using the start/busy call interface and waits for done on the return interface.
- The result goes back to the owning requester on a valid/ready response channel.
- One call is in flight at a time; a watchdog bounds each call.

---
 rtl/poly5_arbiter.sv | 172 +++++++++++++++++
 tb/tb_poly5_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/poly5_arbiter.sv
// rtl/poly5_arbiter.sv - round-robin arbiter sharing one poly5 call/return interface
module poly5_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*IDX_W-1:0] req_idx,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_err,
    output logic                     pe_start,
    input  logic                     pe_busy,
    output logic [IDX_W-1:0]         pe_idx,
    input  logic                     pe_done,
    output logic                     pe_stall,
    input  logic [DATA_W-1:0]        pe_returndata,
    output logic                     stray_done
);
    localparam int GW = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [GW-1:0]    LAST_INIT = GW'(NUM_REQ - 1);
    localparam bit               WDOG_EN   = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     owner;
    logic [GW-1:0]     winner;
    logic [GW-1:0]     cand;
    logic              found;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;
    logic [CNT_W-1:0]  wdog;
    logic              stray_q;
    logic              wdog_expired;
    logic              owner_ack;

    assign wdog_expired = WDOG_EN && (wdog == WDOG_LAST);
    assign owner_ack    = rsp_ready[owner];

    // Round-robin pick: first valid requester after last_grant, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; everything forced low while in reset.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        pe_start  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    req_ready[winner] = 1'b1;
                    state_nxt         = ISSUE;
                end
            end
            ISSUE: begin
                pe_start = 1'b1;
                if (!pe_busy) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (pe_done || wdog_expired) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid[owner] = 1'b1;
                if (owner_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) begin
            req_ready = '0;
            rsp_valid = '0;
            pe_start  = 1'b0;
        end
    end

    // Call bookkeeping: owner, argument, watchdog, captured result, stray flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= LAST_INIT;
            owner      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            wdog       <= '0;
            stray_q    <= 1'b0;
        end else begin
            if (pe_done && (state != WAIT)) begin
                stray_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        owner <= winner;
                        idx_q <= req_idx[int'(winner)*IDX_W +: IDX_W];
                    end
                end
                ISSUE: begin
                    if (!pe_busy) begin
                        wdog <= '0;
                    end
                end
                WAIT: begin
                    // A done arriving together with expiry still delivers the real result.
                    if (pe_done) begin
                        data_q <= pe_returndata;
                        err_q  <= 1'b0;
                    end else if (wdog_expired) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                    end else begin
                        wdog <= wdog + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (owner_ack) begin
                        last_grant <= owner;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_data   = reset ? '0 : data_q;
    assign rsp_err    = reset ? 1'b0 : err_q;
    assign pe_idx     = reset ? '0 : idx_q;
    assign stray_done = reset ? 1'b0 : stray_q;
    assign pe_stall   = 1'b0;

endmodule

// File: tb/tb_poly5_arbiter.sv
// tb/tb_poly5_arbiter.sv - scoreboard bench for poly5_arbiter
module tb_poly5_arbiter;
    localparam int NR = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [127:0]  req_idx;
    logic [NR-1:0] rsp_valid;
    logic [NR-1:0] rsp_ready;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic          pe_start;
    logic          pe_busy;
    logic [31:0]   pe_idx;
    logic          pe_done;
    logic          pe_stall;
    logic [31:0]   pe_returndata;
    logic          stray_done;

    poly5_arbiter #(
        .NUM_REQ(NR), .IDX_W(32), .DATA_W(32), .TIMEOUT(16), .CNT_W(16)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .pe_start(pe_start), .pe_busy(pe_busy), .pe_idx(pe_idx),
        .pe_done(pe_done), .pe_stall(pe_stall), .pe_returndata(pe_returndata),
        .stray_done(stray_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          who;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   rsp_log[$];

    int n_checks = 0;
    int n_errors = 0;

    int          model_lat   = 7;
    bit          model_never = 1'b0;
    int          busy_left   = 0;
    bit          inject_done = 1'b0;
    logic [31:0] cur_res;
    int          cd;

    int          cyc = 0;
    int          start_cycles = 0;
    int          calls = 0;
    int          idx_changes = 0;
    int          acc_cyc = 0;
    int          done_cyc = 0;
    int          rsp_count = 0;
    int          hold_changes = 0;
    int          ready_during_rsp = 0;
    logic [31:0] start_idx_first = '0;
    logic [31:0] hold_data = '0;
    logic        hold_err = 1'b0;
    logic        start_prev = 1'b0;
    logic        rsp_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pow5(input logic [31:0] x);
        return x * x * x * x * x;
    endfunction

    // poly5 stand-in: programmable busy stall and latency, optional silence, stray injection.
    initial begin
        pe_busy = 1'b0; pe_done = 1'b0; pe_returndata = '0; cd = 0; cur_res = '0;
        forever begin
            @(posedge clock); #1;
            pe_done = 1'b0;
            pe_returndata = '0;
            if (reset) begin
                cd = 0;
                pe_busy = 1'b0;
            end else begin
                if (inject_done) begin
                    pe_done = 1'b1;
                    pe_returndata = 32'd999;
                    inject_done = 1'b0;
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        pe_done = 1'b1;
                        pe_returndata = cur_res;
                    end
                end
                if (pe_start) begin
                    if (busy_left > 0) begin
                        pe_busy = 1'b1;
                        busy_left--;
                    end else begin
                        pe_busy = 1'b0;
                        if (!model_never) begin
                            cd = model_lat;
                            cur_res = pow5(pe_idx);
                        end
                    end
                end else begin
                    pe_busy = 1'b0;
                end
            end
        end
    end

    // Monitor: push expectations on request handshakes, pop and compare on response handshakes.
    always @(negedge clock) begin : monitor
        int   w;
        exp_t e;
        cyc++;
        if (reset) begin
            start_prev = 1'b0;
            rsp_prev = 1'b0;
        end else begin
            if ((req_valid & req_ready) != '0) begin
                check("req_ready_onehot", 64'($countones(req_ready)), 64'd1);
                w = 0;
                for (int i = 0; i < NR; i++) if (req_ready[i]) w = i;
                grant_log.push_back(w);
                e.who = w;
                e.err = model_never;
                e.data = model_never ? 32'd0 : pow5(req_idx[w*32 +: 32]);
                sb.push_back(e);
            end
            if (pe_start) begin
                start_cycles++;
                if (!start_prev) start_idx_first = pe_idx;
                else if (pe_idx != start_idx_first) idx_changes++;
                if (!pe_busy) begin
                    calls++;
                    acc_cyc = cyc;
                end
            end
            start_prev = pe_start;
            if (pe_done) done_cyc = cyc;
            if (rsp_valid != '0) begin
                check("rsp_valid_onehot", 64'($countones(rsp_valid)), 64'd1);
                if (req_ready != '0) ready_during_rsp++;
                if (!rsp_prev) begin
                    hold_data = rsp_data;
                    hold_err = rsp_err;
                    if (rsp_err) check("timeout_wait_cycles", 64'(cyc - acc_cyc), 64'd17);
                    else check("rsp_after_done", 64'(cyc - done_cyc), 64'd1);
                end else if (rsp_data != hold_data || rsp_err != hold_err) begin
                    hold_changes++;
                end
                w = 0;
                for (int i = 0; i < NR; i++) if (rsp_valid[i]) w = i;
                if (rsp_ready[w]) begin
                    if (sb.size() == 0) begin
                        check("rsp_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_owner", 64'(w), 64'(e.who));
                        check("rsp_data", 64'(rsp_data), 64'(e.data));
                        check("rsp_err", 64'(rsp_err), 64'(e.err));
                    end
                    rsp_log.push_back(int'(rsp_data));
                    rsp_count++;
                    rsp_prev = 1'b0;
                end else begin
                    rsp_prev = 1'b1;
                end
            end else begin
                rsp_prev = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic sample();
        @(negedge clock); #1;
    endtask

    task automatic wait_grant(input string tag);
        int n0 = grant_log.size();
        for (int i = 0; i < 100 && grant_log.size() == n0; i++) sample();
        check(tag, 64'(grant_log.size() > n0), 64'd1);
    endtask

    task automatic wait_rsp(input string tag, input int n);
        int r0 = rsp_count;
        for (int i = 0; i < 400 && rsp_count < r0 + n; i++) sample();
        check(tag, 64'(rsp_count >= r0 + n), 64'd1);
    endtask

    task automatic do_reset();
        tick(); reset = 1'b1;
        tick(); tick(); reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
        $fatal(1);
    end

    initial begin : stim
        int s0, c0, i0, r0, g0;
        int exp_order[5];
        int exp_data[5];
        exp_order = '{0, 1, 2, 3, 0};
        exp_data  = '{1, 32, 243, 1024, 1};

        reset = 1'b1; req_valid = '1; rsp_ready = '1; req_idx = '0;
        req_idx[31:0] = 32'd5;
        tick(); tick();
        sample();
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_pe_start", 64'(pe_start), 64'd0);
        check("reset_pe_stall", 64'(pe_stall), 64'd0);
        check("reset_stray", 64'(stray_done), 64'd0);
        tick(); reset = 1'b0; req_valid = '0;

        // single request, 7-cycle call
        model_lat = 7;
        s0 = start_cycles; c0 = calls;
        tick(); req_valid = 4'b0001;
        wait_grant("t1_grant");
        check("t1_grant_id", 64'(grant_log[$]), 64'd0);
        tick(); req_valid = '0;
        wait_rsp("t1_rsp", 1);
        check("t1_start_cycles", 64'(start_cycles - s0), 64'd1);
        check("t1_pe_idx", 64'(start_idx_first), 64'd5);
        check("t1_calls", 64'(calls - c0), 64'd1);
        check("t1_data", 64'(rsp_log[$]), 64'd3125);

        // all requesters continuously valid
        do_reset();
        model_lat = 3;
        req_idx = {32'd4, 32'd3, 32'd2, 32'd1};
        g0 = grant_log.size(); r0 = rsp_log.size();
        req_valid = 4'b1111;
        for (int i = 0; i < 300 && grant_log.size() < g0 + 5; i++) sample();
        check("t2_five_grants", 64'(grant_log.size() >= g0 + 5), 64'd1);
        tick(); req_valid = '0;
        wait_rsp("t2_rsp", 0);
        for (int i = 0; i < 300 && rsp_log.size() < r0 + 5; i++) sample();
        check("t2_five_rsps", 64'(rsp_log.size() >= r0 + 5), 64'd1);
        for (int k = 0; k < 5; k++) begin
            if (grant_log.size() > g0 + k) check("t2_order", 64'(grant_log[g0 + k]), 64'(exp_order[k]));
            if (rsp_log.size() > r0 + k) check("t2_data", 64'(rsp_log[r0 + k]), 64'(exp_data[k]));
        end

        // busy stall during ISSUE
        busy_left = 5; model_lat = 2;
        req_idx[63:32] = 32'd7;
        s0 = start_cycles; c0 = calls; i0 = idx_changes;
        tick(); req_valid = 4'b0010;
        wait_grant("t3_grant");
        tick(); req_valid = '0;
        wait_rsp("t3_rsp", 1);
        check("t3_start_cycles", 64'(start_cycles - s0), 64'd6);
        check("t3_calls", 64'(calls - c0), 64'd1);
        check("t3_idx_stable", 64'(idx_changes - i0), 64'd0);
        check("t3_pe_idx", 64'(start_idx_first), 64'd7);
        check("t3_data", 64'(rsp_log[$]), 64'd16807);

        // watchdog expiry, then a late done
        model_never = 1'b1;
        req_idx[95:64] = 32'd9;
        tick(); req_valid = 4'b0100;
        wait_grant("t4_grant");
        tick(); req_valid = '0;
        wait_rsp("t4_rsp", 1);
        check("t4_no_stray_yet", 64'(stray_done), 64'd0);
        for (int i = 0; i < 60 && cyc < acc_cyc + 19; i++) sample();
        r0 = rsp_count;
        tick(); inject_done = 1'b1;
        for (int i = 0; i < 4; i++) sample();
        check("t4_stray_set", 64'(stray_done), 64'd1);
        check("t4_no_extra_rsp", 64'(rsp_count), 64'(r0));
        model_never = 1'b0;

        // response back-pressure with non-owner rsp_ready high
        model_lat = 3;
        req_idx[127:96] = 32'd2;
        rsp_ready = 4'b0111;
        tick(); req_valid = 4'b1000;
        wait_grant("t5_grant");
        tick(); req_valid = 4'b0011;
        for (int i = 0; i < 100 && rsp_valid == '0; i++) sample();
        check("t5_rsp_seen", 64'(rsp_valid), 64'b1000);
        s0 = hold_changes; i0 = ready_during_rsp; g0 = grant_log.size();
        for (int i = 0; i < 10; i++) tick();
        sample();
        check("t5_still_valid", 64'(rsp_valid), 64'b1000);
        check("t5_hold_stable", 64'(hold_changes - s0), 64'd0);
        check("t5_no_req_ready", 64'(ready_during_rsp - i0), 64'd0);
        check("t5_no_grant", 64'(grant_log.size()), 64'(g0));
        tick(); rsp_ready = '1;
        wait_grant("t5_next_grant");
        check("t5_next_is_0", 64'(grant_log[$]), 64'd0);
        tick(); req_valid = '0;
        wait_rsp("t5_rsp", 1);

        // reset while waiting for done
        model_never = 1'b1;
        req_idx[63:32] = 32'd3;
        c0 = calls;
        tick(); req_valid = 4'b0010;
        wait_grant("t6_grant");
        tick(); req_valid = '0;
        for (int i = 0; i < 50 && calls == c0; i++) sample();
        tick(); tick();
        reset = 1'b1; req_valid = 4'b1111;
        sb.delete();
        sample();
        check("t6_rst_req_ready", 64'(req_ready), 64'd0);
        check("t6_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t6_rst_pe_start", 64'(pe_start), 64'd0);
        check("t6_rst_pe_idx", 64'(pe_idx), 64'd0);
        check("t6_rst_data_err", 64'({rsp_data, rsp_err}), 64'd0);
        check("t6_rst_stray", 64'(stray_done), 64'd0);
        tick(); reset = 1'b0; req_valid = '0; model_never = 1'b0;
        sample();
        check("t6_idle_outputs", 64'({req_ready, rsp_valid, pe_start, pe_idx, stray_done}), 64'd0);
        req_idx = {32'd4, 32'd3, 32'd2, 32'd1};
        tick(); req_valid = 4'b1111;
        sample();
        check("t6_first_grant", 64'(req_ready), 64'b0001);
        tick(); req_valid = '0;
        wait_rsp("t6_rsp", 1);
        check("t6_data", 64'(rsp_log[$]), 64'd1);

        for (int i = 0; i < 5; i++) sample();
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
